// File: rtl/div.sv
// div: 32-bit signed restoring divider, 33-cycle fixed latency; macro DIV_ZERO_DETECT_EN enables early divide-by-zero completion
module div (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        divControl,
    output logic        divStop,
    output logic        divZero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_b_mag, r_quo, r_rem, r_hi, r_lo;
    logic [5:0]  r_cnt;
    logic        r_a_neg, r_b_neg, r_zero, r_stop;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_shift, w_trial;
    logic        w_b_zero, w_step, w_done, w_write;
    assign w_a_mag = a[31] ? -a : a;
    assign w_b_mag = b[31] ? -b : b;
    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_b_mag};
`ifdef DIV_ZERO_DETECT_EN
    logic r_dz;
    assign w_b_zero = (b == 32'd0);
    assign divZero  = r_dz;
    // divide-by-zero flag pulses alongside divStop on the short completion path
    always_ff @(posedge clk) begin
        if (Reset) r_dz <= 1'b0;
        else       r_dz <= w_done && r_zero;
    end
`else
    assign w_b_zero = 1'b0;
    assign divZero  = 1'b0;
`endif
    assign divStop = r_stop;
    assign hi      = r_hi;
    assign lo      = r_lo;
    // state register
    always_ff @(posedge clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // next state: a start request from any state (re)starts; zero divisor skips straight to FIX
    always_comb begin
        w_next = r_state;
        if (divControl)              w_next = w_b_zero ? FIX : RUN;
        else if (r_state == RUN)     w_next = (r_cnt == 6'd1) ? FIX : RUN;
        else if (r_state == FIX)     w_next = IDLE;
    end
    // per-state controls; a new start suppresses the step and completion of the old one
    always_comb begin
        w_step  = (r_state == RUN) && !divControl;
        w_done  = (r_state == FIX) && !divControl;
        w_write = w_done && !r_zero;
    end
    // operand latch and one restoring step per RUN cycle; dividend magnitude shifts out of the quotient register
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_b_mag <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
        end else if (divControl) begin
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_b_mag <= w_b_mag;
            r_a_neg <= a[31];
            r_b_neg <= b[31];
            r_zero  <= w_b_zero;
            r_cnt   <= 6'd32;
        end else if (w_step) begin
            r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
            r_quo <= {r_quo[30:0], ~w_trial[32]};
            r_cnt <= r_cnt - 6'd1;
        end
    end
    // sign fix-up into the result registers and the one-cycle done pulse
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_stop <= 1'b0;
        end else begin
            r_stop <= w_done;
            if (w_write) begin
                r_lo <= (r_a_neg ^ r_b_neg) ? -r_quo : r_quo;
                r_hi <= r_a_neg ? -r_rem : r_rem;
            end
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the signed divider with directed vectors
module tb_div;
    logic        clk = 1'b0, Reset = 1'b1, divControl = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        divStop, divZero;
    logic [31:0] hi, lo;
    typedef struct { int at; logic [31:0] eh; logic [31:0] el; logic ez; } exp_t;
    exp_t        q[$];
    exp_t        e;
    int          cyc = 0, checks = 0, fails = 0, n;
    logic [31:0] last_hi = '0, last_lo = '0;

    div dut (.clk(clk), .Reset(Reset), .a(a), .b(b), .divControl(divControl),
             .divStop(divStop), .divZero(divZero), .hi(hi), .lo(lo));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (divStop) begin
            if (q.size() == 0) chk("spurious_divStop", 32'(divStop), 32'd0);
            else begin
                e = q.pop_front();
                chk("done_edge", cyc, e.at);
                chk("lo", lo, e.el);
                chk("hi", hi, e.eh);
                chk("divZero", 32'(divZero), 32'(e.ez));
            end
        end else if (q.size() != 0 && cyc > q[0].at) begin
            chk("missing_divStop_edge", cyc, q[0].at);
            void'(q.pop_front());
        end
    end

    // called at a negedge; the start edge is the following posedge
    task automatic start(input logic [31:0] av, input logic [31:0] bv, input bit push,
                         input logic [31:0] el, input logic [31:0] eh);
        exp_t x;
        a = av; b = bv; divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        if (push) begin
`ifdef DIV_ZERO_DETECT_EN
            if (bv == 32'd0) begin
                x = '{cyc + 1, last_hi, last_lo, 1'b1};
                q.push_back(x);
                return;
            end
`endif
            x = '{cyc + 33, eh, el, 1'b0};
            q.push_back(x);
            last_hi = eh; last_lo = el;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_divStop", 32'(divStop), 32'd0);
        chk("reset_divZero", 32'(divZero), 32'd0);
        Reset = 1'b0;
        start(32'd7,          32'd2,          1, 32'd3,          32'd1);          drain();
        start(32'hFFFFFFF9,   32'd2,          1, 32'hFFFFFFFD,   32'hFFFFFFFF);   drain();
        start(32'd7,          32'hFFFFFFFE,   1, 32'hFFFFFFFD,   32'd1);          drain();
        start(32'h80000000,   32'hFFFFFFFF,   1, 32'h80000000,   32'd0);          drain();
        start(32'hFFFFFF9C,   32'hFFFFFFF9,   1, 32'd14,         32'hFFFFFFFE);   drain();
        start(32'd0,          32'd5,          1, 32'd0,          32'd0);          drain();
        start(32'h7FFFFFFF,   32'd1,          1, 32'h7FFFFFFF,   32'd0);          drain();
        start(32'd5,          32'd0,          1, 32'hFFFFFFFF,   32'd5);          drain();
        // reset mid-run, with a simultaneous start request that must be ignored
        start(32'd100, 32'd7, 0, 32'd0, 32'd0);
        n = cyc;
        repeat (9) @(negedge clk);
        Reset = 1'b1; divControl = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        Reset = 1'b0; divControl = 1'b0;
        last_hi = '0; last_lo = '0;
        while (cyc < n + 50) begin
            chk("post_reset_hi", hi, 32'd0);
            chk("post_reset_lo", lo, 32'd0);
            @(negedge clk);
        end
        start(32'd100, 32'd7, 1, 32'd14, 32'd2); drain();
        // restart five edges into a run; only the second produces a result
        start(32'd100, 32'd7, 0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        start(32'd9, 32'd3, 1, 32'd3, 32'd0); drain();
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port a  input  32  dividend, two's complement, sampled on the start edge only.
REQ-004 SHALL have port b  input  32  divisor, two's complement, sampled on the start edge only.
REQ-005 SHALL have port divControl  input  1  start request, one-cycle pulse, sampled at posedge.
REQ-006 SHALL have port divStop  output  1  done pulse; hi/lo valid from the same edge.
REQ-007 SHALL have port divZero  output  1  divide-by-zero flag; constant 0 when DIV_ZERO_DETECT_EN is undefined.
REQ-008 SHALL have port hi  output  32  remainder register.
REQ-009 SHALL have port lo  output  32  quotient register.

Function
REQ-010 SHALL implement states IDLE, RUN, FIX.
- IDLE -> RUN on divControl=1.
- RUN -> FIX after 32 iterations.
- FIX -> IDLE unconditionally.
REQ-011 On the start edge, SHALL latch:
- |a| and |b| as 32-bit unsigned magnitudes.
- The sign bits a[31] and b[31].
- Clear the 33-bit partial remainder.
- Load iteration counter = 32.
REQ-012 Each RUN edge SHALL perform one restoring step:
- Shift {remainder, quotient} left by 1.
- Trial-subtract |b| from the remainder in 33 bits.
- If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
- Decrement the counter.
REQ-013 In FIX, SHALL:
- Write lo = quotient, negated if a[31] != b[31].
- Write hi = remainder, negated if a[31] = 1.
- Assert divStop=1 for exactly this one cycle.
REQ-014 Latency SHALL be fixed: start on edge N -> hi/lo/divStop updated at edge N+33; divStop returns to 0 at edge N+34.
REQ-015 hi/lo SHALL hold their last values at all times outside FIX and the divide-by-zero completion cycle.
REQ-016 divControl=1 in RUN or FIX SHALL abort the current operation and restart per REQ-011; the aborted operation produces no divStop.
REQ-017 Overflow case a=0x80000000, b=0xFFFFFFFF SHALL produce lo=0x80000000, hi=0x00000000, with no flag.
REQ-018 Results SHALL satisfy a = lo*b + hi (mod 2^32), with |hi| < |b| and sign(hi) = sign(a) or hi = 0, for every b != 0.

Reset
REQ-019 Reset=1 at a posedge SHALL force IDLE, hi=0, lo=0, divStop=0, divZero=0, and clear all internal registers.
REQ-020 Reset SHALL take priority over a simultaneous divControl=1; no operation starts on that edge.
REQ-021 Reset during RUN or FIX SHALL discard the operation; no divStop follows.

Configuration
REQ-022 Macro DIV_ZERO_DETECT_EN SHALL select divide-by-zero handling.
- Defined: b=0 on the start edge skips RUN. The next edge asserts divStop=1 and divZero=1 for one cycle, leaves hi/lo unchanged, and returns to IDLE.
- Undefined: b=0 runs the normal 33-cycle path. Result is hi=a, and lo=0xFFFFFFFF if a[31]=0, else lo=0x00000001. divZero is tied to 0.

Verification
REQ-023 a=7, b=2, one-cycle start -> at edge start+33: lo=0x00000003, hi=0x00000001, divStop high for 1 cycle.
REQ-024 a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-025 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, divZero=0.
REQ-026 a=5, b=0:
- DIV_ZERO_DETECT_EN defined -> divStop=divZero=1 at edge start+1; hi/lo keep prior values.
- Undefined -> at start+33: hi=0x00000005, lo=0xFFFFFFFF.
REQ-027 Start a=100, b=7; assert Reset at start+10 -> hi=lo=0 and no divStop through start+40; then a=100, b=7 -> lo=14, hi=2.
REQ-028 Start a=100, b=7; re-start with a=9, b=3 at start+5 -> a single divStop at (start+5)+33 with lo=3, hi=0.
